// File: rtl/chan_mux_reg.sv
// N-channel registered multiplexer with valid/ready handshakes on every port.
// The grant comes either from the sel port or from a rotating-priority arbiter.
module chan_mux_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned USE_RR = 0,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             ld;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] out_ch_q;

  // Single-entry output stage: it can reload in the same cycle it drains.
  assign ld   = ~out_valid_q | out_ready;
  assign xfer = ld & grant_valid;

  generate
    if (USE_RR == 0) begin : g_fixed
      assign grant = sel;

      // An out-of-range sel matches no channel, so nothing is granted.
      always_comb begin
        grant_valid = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (sel == SEL_W'(i)) grant_valid = in_valid[i];
        end
      end
    end else begin : g_rr
      logic [SEL_W-1:0] ptr_q, ptr_d;
      logic             found;
      int               idx;
      logic             unused_sel;

      assign unused_sel  = ^sel;
      assign grant_valid = |in_valid;

      // First requester at or after ptr, wrapping around.
      always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
          idx = (int'(ptr_q) + k) % int'(NUM_CH);
          if (!found && in_valid[idx]) begin
            grant = SEL_W'(idx);
            found = 1'b1;
          end
        end
      end

      always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
          ptr_d = (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_q <= '0;
        end else begin
          ptr_q <= ptr_d;
        end
      end
    end
  endgenerate

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      in_ready[i] = xfer & (grant == SEL_W'(i));
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (ld) begin
      out_valid_q <= grant_valid;
      if (grant_valid) begin
        out_data_q <= grant_data;
        out_ch_q   <= grant;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
